speriph_port_arbiter: RTL and testbench
=======================================

SPERIPH_PORT_ARBITER -- requirements
Module: speriph_port_arbiter

Interface
REQ-001 SHALL have parameter NB_MASTERS, default 8: number of requesting masters (cores plus DMA) sharing one peripheral slave plug.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32: request address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 32: data width; BE_WIDTH = DATA_WIDTH/8.
REQ-004 SHALL have parameter MAX_OUTSTANDING, default 4: maximum accepted-but-unanswered transactions, at least 1.
REQ-005 SHALL have port clk_i, input, 1: the only clock.
REQ-006 SHALL have port rst_ni, input, 1: asynchronous active-low reset.
REQ-007 SHALL have ports req_i[NB_MASTERS], add_i[NB_MASTERS][ADDR_WIDTH], wen_i[NB_MASTERS] (1 = read), wdata_i[NB_MASTERS][DATA_WIDTH], be_i[NB_MASTERS][BE_WIDTH], all inputs: master requests.
REQ-008 SHALL have outputs gnt_o[NB_MASTERS], r_valid_o[NB_MASTERS], r_rdata_o[DATA_WIDTH] and r_opc_o (1 = error): master grants and responses.
REQ-009 SHALL have outputs req_o, add_o, wen_o, wdata_o, be_o and id_o[NB_MASTERS] (one-hot initiator): the slave-side request.
REQ-010 SHALL have inputs gnt_i, r_valid_i, r_id_i[NB_MASTERS], r_rdata_i and r_opc_i: the slave-side grant and response.
REQ-011 SHALL have output err_o, 1: sticky protocol-error flag.

Function
REQ-012 SHALL pick one winner per cycle, round-robin, among masters with req_i high: search starts at pointer rr_q and wraps modulo NB_MASTERS.
REQ-013 SHALL drive req_o = winner valid AND outstanding count cnt_q < MAX_OUTSTANDING; add_o, wen_o, wdata_o and be_o come from the winner; id_o is the winner one-hot; all are zero when there is no winner.
REQ-014 SHALL drive gnt_o[w] = req_o AND gnt_i for winner w only, combinationally, in the same cycle.
REQ-015 SHALL set rr_q to (w+1) mod NB_MASTERS at the end of a cycle with a handshake (req_o AND gnt_i); rr_q SHALL be held otherwise, so a stalled winner keeps priority.
REQ-016 SHALL hold req_o low when cnt_q == MAX_OUTSTANDING, regardless of req_i.
REQ-017 SHALL increment cnt_q on handshake, decrement it on r_valid_i, and hold it when both occur in the same cycle.
REQ-018 SHALL drive r_valid_o = r_id_i AND {r_valid_i}; r_rdata_o = r_rdata_i and r_opc_o = r_opc_i pass through unregistered (zero latency).
REQ-019 SHALL set err_o on r_valid_i with cnt_q == 0 (cnt_q stays 0, no underflow), and on r_valid_i with r_id_i not one-hot (no r_valid_o asserted).
REQ-020 SHALL keep err_o set until reset.
REQ-021 SHALL never change add_o, wdata_o, wen_o or be_o while req_o is high and gnt_i is low, unless the winning master drops req_i.

Reset
REQ-022 SHALL, on rst_ni low, asynchronously set rr_q = 0, cnt_q = 0 and err_o = 0.
REQ-023 SHALL drive all request-side outputs to zero while in reset.
REQ-024 SHALL forget outstanding transactions that are reset mid-flight: after reset, responses to them raise err_o per REQ-019.

Structure
REQ-025 SHALL take the default NB_MASTERS and MAX_OUTSTANDING constants from the shared cluster package, next to the SPER_*_ID plug indices; each SPER plug SHALL instantiate one arbiter.
REQ-026 SHALL place the combinational pointer-based priority search in one sub-module, speriph_rr_select (inputs req vector and pointer; outputs winner index and valid).
REQ-027 SHALL keep cnt_q at width clog2(MAX_OUTSTANDING+1) bits.

Verification
REQ-028 SHALL cover: req_i=8'hFF held, gnt_i=1, r_valid_i answered each next cycle -> grants to masters 0,1,...,7,0 on consecutive cycles.
REQ-029 SHALL cover: masters 2 and 5 requesting, gnt_i=0 for 3 cycles then 1 -> id_o stays 8'h04 with stable add_o, then grant to 2, next cycle grant to 5.
REQ-030 SHALL cover: MAX_OUTSTANDING=4, 4 handshakes with no responses -> req_o=0 on the 5th cycle; one r_valid_i -> req_o=1 on the next cycle.
REQ-031 SHALL cover: handshake and r_valid_i in the same cycle with cnt_q=2 -> cnt_q stays 2.
REQ-032 SHALL cover: r_valid_i with cnt_q=0, then r_id_i=8'h06 -> err_o=1 after the first event, no r_valid_o on either, err_o held until rst_ni low.
REQ-033 SHALL cover: rst_ni pulsed low with cnt_q=3 and rr_q=5 -> cnt_q=0, rr_q=0, err_o=0; the next grant goes to the lowest-index requester.

Source files
------------

// File: rtl/speriph_port_arbiter_pkg.sv
// Shared cluster constants for the peripheral interconnect plugs
// and small helpers used by the per-plug arbiters.
package speriph_port_arbiter_pkg;

   localparam int SPER_NB_MASTERS      = 8;
   localparam int SPER_MAX_OUTSTANDING = 4;

   localparam int SPER_EOC_ID      = 0;
   localparam int SPER_TIMER_ID    = 1;
   localparam int SPER_EVENT_U_ID  = 2;
   localparam int SPER_HWPE_ID     = 3;
   localparam int SPER_ICACHE_ID   = 4;
   localparam int SPER_DMA_ID      = 5;
   localparam int SPER_EXT_ID      = 6;
   localparam int SPER_DBG_ID      = 7;
   localparam int NB_SPERIPH_PLUGS = 8;

   function automatic int rr_next(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/speriph_port_arbiter_rr_select.sv
// Pointer-based priority search: first requester at or after
// ptr_i, wrapping around the request vector.
module speriph_rr_select #(
   parameter int N  = 8,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] ptr_i,
   output logic [IW-1:0] idx_o,
   output logic          valid_o
);

   int            j;
   logic [IW-1:0] jj;

   always_comb begin
      idx_o   = '0;
      valid_o = 1'b0;
      j       = 0;
      jj      = '0;
      for (int i = 0; i < N; i++) begin
         j = int'(ptr_i) + i;
         if (j >= N) j = j - N;
         jj = IW'(j);
         if (!valid_o && req_i[jj]) begin
            valid_o = 1'b1;
            idx_o   = jj;
         end
      end
   end

endmodule

// File: rtl/speriph_port_arbiter.sv
// Round-robin arbiter sharing one peripheral slave plug among the
// cluster masters, with outstanding-transaction limiting.
module speriph_port_arbiter
   import speriph_port_arbiter_pkg::*;
#(
   parameter int NB_MASTERS      = SPER_NB_MASTERS,
   parameter int ADDR_WIDTH      = 32,
   parameter int DATA_WIDTH      = 32,
   parameter int MAX_OUTSTANDING = SPER_MAX_OUTSTANDING,
   parameter int BE_WIDTH        = DATA_WIDTH / 8
) (
   input  logic                                  clk_i,
   input  logic                                  rst_ni,
   input  logic [NB_MASTERS-1:0]                 req_i,
   input  logic [NB_MASTERS-1:0][ADDR_WIDTH-1:0] add_i,
   input  logic [NB_MASTERS-1:0]                 wen_i,
   input  logic [NB_MASTERS-1:0][DATA_WIDTH-1:0] wdata_i,
   input  logic [NB_MASTERS-1:0][BE_WIDTH-1:0]   be_i,
   output logic [NB_MASTERS-1:0]                 gnt_o,
   output logic [NB_MASTERS-1:0]                 r_valid_o,
   output logic [DATA_WIDTH-1:0]                 r_rdata_o,
   output logic                                  r_opc_o,
   output logic                                  req_o,
   output logic [ADDR_WIDTH-1:0]                 add_o,
   output logic                                  wen_o,
   output logic [DATA_WIDTH-1:0]                 wdata_o,
   output logic [BE_WIDTH-1:0]                   be_o,
   output logic [NB_MASTERS-1:0]                 id_o,
   input  logic                                  gnt_i,
   input  logic                                  r_valid_i,
   input  logic [NB_MASTERS-1:0]                 r_id_i,
   input  logic [DATA_WIDTH-1:0]                 r_rdata_i,
   input  logic                                  r_opc_i,
   output logic                                  err_o
);

   localparam int IW = (NB_MASTERS > 1) ? $clog2(NB_MASTERS) : 1;
   localparam int CW = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUTSTANDING);

   logic [IW-1:0] rr_q, rr_d;
   logic [IW-1:0] lock_idx_q, lock_idx_d;
   logic          lock_q, lock_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          err_q, err_d;

   logic [IW-1:0] sel_idx, win_idx;
   logic          sel_valid, win_valid;
   logic          hs, dec, id_onehot, resp_ok, resp_bad;

   speriph_rr_select #(
      .N  (NB_MASTERS),
      .IW (IW)
   ) u_rr_select (
      .req_i   (req_i),
      .ptr_i   (rr_q),
      .idx_o   (sel_idx),
      .valid_o (sel_valid)
   );

   // A stalled winner stays locked so the slave sees a stable request.
   always_comb begin
      win_idx   = sel_idx;
      win_valid = sel_valid;
      if (lock_q && req_i[lock_idx_q]) begin
         win_idx   = lock_idx_q;
         win_valid = 1'b1;
      end
      if (!rst_ni) win_valid = 1'b0;
   end

   always_comb begin
      req_o   = win_valid && (cnt_q < CNT_MAX);
      add_o   = '0;
      wen_o   = 1'b0;
      wdata_o = '0;
      be_o    = '0;
      id_o    = '0;
      gnt_o   = '0;
      if (win_valid) begin
         add_o         = add_i[win_idx];
         wen_o         = wen_i[win_idx];
         wdata_o       = wdata_i[win_idx];
         be_o          = be_i[win_idx];
         id_o[win_idx] = 1'b1;
      end
      if (req_o && gnt_i) gnt_o[win_idx] = 1'b1;
   end

   assign hs        = req_o && gnt_i;
   assign id_onehot = (r_id_i != '0)
                   && ((r_id_i & (r_id_i - NB_MASTERS'(1))) == '0);
   assign dec       = r_valid_i && (cnt_q != '0);
   assign resp_ok   = dec && id_onehot;
   assign resp_bad  = r_valid_i && (!id_onehot || (cnt_q == '0));

   assign r_valid_o = resp_ok ? r_id_i : '0;
   assign r_rdata_o = r_rdata_i;
   assign r_opc_o   = r_opc_i;
   assign err_o     = err_q;

   always_comb begin
      rr_d       = rr_q;
      lock_d     = req_o && !gnt_i;
      lock_idx_d = win_idx;
      cnt_d      = cnt_q;
      err_d      = err_q || resp_bad;
      if (hs) rr_d = IW'(rr_next(int'(win_idx), NB_MASTERS));
      case ({hs, dec})
         2'b10:   cnt_d = cnt_q + CW'(1);
         2'b01:   cnt_d = cnt_q - CW'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rr_q       <= '0;
         lock_q     <= 1'b0;
         lock_idx_q <= '0;
         cnt_q      <= '0;
         err_q      <= 1'b0;
      end else begin
         rr_q       <= rr_d;
         lock_q     <= lock_d;
         lock_idx_q <= lock_idx_d;
         cnt_q      <= cnt_d;
         err_q      <= err_d;
      end
   end

endmodule

// File: tb/tb_speriph_port_arbiter.sv
// Directed scoreboard bench for speriph_port_arbiter.
// Stimulus queues expected grants/responses; a monitor pops them.
module tb_speriph_port_arbiter;

   localparam int NB = 8;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int BW = 4;
   localparam int MO = 4;

   logic                   clk_i = 1'b0;
   logic                   rst_ni;
   logic [NB-1:0]          req_i;
   logic [NB-1:0][AW-1:0]  add_i;
   logic [NB-1:0]          wen_i;
   logic [NB-1:0][DW-1:0]  wdata_i;
   logic [NB-1:0][BW-1:0]  be_i;
   logic [NB-1:0]          gnt_o;
   logic [NB-1:0]          r_valid_o;
   logic [DW-1:0]          r_rdata_o;
   logic                   r_opc_o;
   logic                   req_o;
   logic [AW-1:0]          add_o;
   logic                   wen_o;
   logic [DW-1:0]          wdata_o;
   logic [BW-1:0]          be_o;
   logic [NB-1:0]          id_o;
   logic                   gnt_i;
   logic                   r_valid_i;
   logic [NB-1:0]          r_id_i;
   logic [DW-1:0]          r_rdata_i;
   logic                   r_opc_i;
   logic                   err_o;

   always #5 clk_i = ~clk_i;

   speriph_port_arbiter #(
      .NB_MASTERS      (NB),
      .ADDR_WIDTH      (AW),
      .DATA_WIDTH      (DW),
      .MAX_OUTSTANDING (MO)
   ) dut (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .req_i     (req_i),
      .add_i     (add_i),
      .wen_i     (wen_i),
      .wdata_i   (wdata_i),
      .be_i      (be_i),
      .gnt_o     (gnt_o),
      .r_valid_o (r_valid_o),
      .r_rdata_o (r_rdata_o),
      .r_opc_o   (r_opc_o),
      .req_o     (req_o),
      .add_o     (add_o),
      .wen_o     (wen_o),
      .wdata_o   (wdata_o),
      .be_o      (be_o),
      .id_o      (id_o),
      .gnt_i     (gnt_i),
      .r_valid_i (r_valid_i),
      .r_id_i    (r_id_i),
      .r_rdata_i (r_rdata_i),
      .r_opc_i   (r_opc_i),
      .err_o     (err_o)
   );

   typedef struct {
      logic [NB-1:0] gnt;
      logic [AW-1:0] add;
      logic [DW-1:0] wdata;
      logic          wen;
   } g_exp_t;

   typedef struct {
      logic [NB-1:0] id;
      logic [DW-1:0] rdata;
      logic          opc;
   } r_exp_t;

   g_exp_t gq[$];
   r_exp_t rq[$];
   int n_run  = 0;
   int n_fail = 0;

   function automatic logic [AW-1:0] addr_of(input int m);
      return 32'h4000_0000 + 32'(m) * 32'h100;
   endfunction

   function automatic logic [DW-1:0] wdata_of(input int m);
      return 32'hCAFE_0000 + 32'(m);
   endfunction

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      n_run++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic nxt();
      @(posedge clk_i);
      #1;
   endtask

   task automatic exp_gnt(input int m);
      g_exp_t e;
      e.gnt   = NB'(1) << m;
      e.add   = addr_of(m);
      e.wdata = wdata_of(m);
      e.wen   = m[0];
      gq.push_back(e);
   endtask

   task automatic resp(input int m);
      r_exp_t e;
      r_valid_i = 1'b1;
      r_id_i    = NB'(1) << m;
      r_rdata_i = 32'hD00D_0000 + 32'(m);
      r_opc_i   = m[0];
      e.id      = r_id_i;
      e.rdata   = r_rdata_i;
      e.opc     = r_opc_i;
      rq.push_back(e);
   endtask

   task automatic idle_resp();
      r_valid_i = 1'b0;
      r_id_i    = '0;
      r_rdata_i = '0;
      r_opc_i   = 1'b0;
   endtask

   g_exp_t ge;
   r_exp_t re;

   always @(negedge clk_i) begin
      if (rst_ni) begin
         if (gnt_o != '0) begin
            if (gq.size() == 0) begin
               chk("unexpected_gnt", 64'(gnt_o), 64'd0);
            end else begin
               ge = gq.pop_front();
               chk("gnt_o", 64'(gnt_o), 64'(ge.gnt));
               chk("add_o", 64'(add_o), 64'(ge.add));
               chk("wdata_o", 64'(wdata_o), 64'(ge.wdata));
               chk("wen_o", 64'(wen_o), 64'(ge.wen));
            end
         end
         if (r_valid_o != '0) begin
            if (rq.size() == 0) begin
               chk("unexpected_rvalid", 64'(r_valid_o), 64'd0);
            end else begin
               re = rq.pop_front();
               chk("r_valid_o", 64'(r_valid_o), 64'(re.id));
               chk("r_rdata_o", 64'(r_rdata_o), 64'(re.rdata));
               chk("r_opc_o", 64'(r_opc_o), 64'(re.opc));
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: run did not finish");
      $fatal(1);
   end

   initial begin
      for (int m = 0; m < NB; m++) begin
         add_i[3'(m)]   = addr_of(m);
         wdata_i[3'(m)] = wdata_of(m);
         wen_i[3'(m)]   = m[0];
         be_i[3'(m)]    = 4'hF;
      end
      req_i  = '1;
      gnt_i  = 1'b1;
      idle_resp();
      rst_ni = 1'b0;
      #3;
      chk("rst_req_o", 64'(req_o), 64'd0);
      chk("rst_id_o", 64'(id_o), 64'd0);
      chk("rst_add_o", 64'(add_o), 64'd0);
      chk("rst_gnt_o", 64'(gnt_o), 64'd0);
      req_i = '0;
      gnt_i = 1'b0;
      repeat (2) @(posedge clk_i);
      #1;
      rst_ni = 1'b1;
      chk("rst_cnt", 64'(dut.cnt_q), 64'd0);
      chk("rst_rr", 64'(dut.rr_q), 64'd0);
      chk("rst_err", 64'(err_o), 64'd0);

      // full round robin with every master requesting
      gnt_i = 1'b1;
      req_i = '1;
      for (int k = 0; k < 9; k++) begin
         exp_gnt(k % NB);
         if (k > 0) resp((k - 1) % NB);
         else idle_resp();
         @(negedge clk_i);
         chk("rr_req_o", 64'(req_o), 64'd1);
         nxt();
      end
      req_i = '0;
      resp(0);
      nxt();
      idle_resp();
      chk("rr_cnt", 64'(dut.cnt_q), 64'd0);
      chk("rr_ptr", 64'(dut.rr_q), 64'd1);

      // stalled winner keeps priority and stable payload
      gnt_i = 1'b0;
      req_i = 8'h24;
      for (int k = 0; k < 3; k++) begin
         if (k == 1) req_i = 8'h26;
         @(negedge clk_i);
         chk("stall_req_o", 64'(req_o), 64'd1);
         chk("stall_id_o", 64'(id_o), 64'h04);
         chk("stall_add_o", 64'(add_o), 64'(addr_of(2)));
         nxt();
      end
      gnt_i = 1'b1;
      exp_gnt(2);
      nxt();
      exp_gnt(5);
      nxt();
      exp_gnt(1);
      nxt();
      req_i = '0;
      gnt_i = 1'b0;
      chk("stall_cnt", 64'(dut.cnt_q), 64'd3);
      chk("stall_rr", 64'(dut.rr_q), 64'd2);
      resp(2);
      nxt();
      resp(5);
      nxt();
      resp(1);
      nxt();
      idle_resp();
      chk("stall_cnt0", 64'(dut.cnt_q), 64'd0);

      // outstanding limit
      req_i = 8'h08;
      gnt_i = 1'b1;
      for (int k = 0; k < MO; k++) begin
         exp_gnt(3);
         @(negedge clk_i);
         chk("lim_req_o", 64'(req_o), 64'd1);
         nxt();
      end
      @(negedge clk_i);
      chk("full_req_o", 64'(req_o), 64'd0);
      chk("full_gnt_o", 64'(gnt_o), 64'd0);
      nxt();
      chk("full_cnt", 64'(dut.cnt_q), 64'd4);
      resp(3);
      @(negedge clk_i);
      chk("full_resp_req_o", 64'(req_o), 64'd0);
      nxt();
      idle_resp();
      exp_gnt(3);
      @(negedge clk_i);
      chk("refill_req_o", 64'(req_o), 64'd1);
      nxt();
      req_i = '0;
      resp(3);
      nxt();
      resp(3);
      nxt();
      idle_resp();
      chk("lim_cnt2", 64'(dut.cnt_q), 64'd2);

      // handshake and response in the same cycle
      req_i = 8'h08;
      exp_gnt(3);
      resp(3);
      nxt();
      req_i = '0;
      chk("both_cnt", 64'(dut.cnt_q), 64'd2);
      resp(3);
      nxt();
      resp(3);
      nxt();
      idle_resp();
      chk("both_cnt0", 64'(dut.cnt_q), 64'd0);
      chk("both_rr", 64'(dut.rr_q), 64'd4);

      // reset mid-flight
      req_i = 8'h10;
      for (int k = 0; k < 3; k++) begin
         exp_gnt(4);
         nxt();
      end
      gnt_i = 1'b0;
      chk("pre_rst_cnt", 64'(dut.cnt_q), 64'd3);
      chk("pre_rst_rr", 64'(dut.rr_q), 64'd5);
      #2;
      rst_ni = 1'b0;
      #1;
      chk("mid_rst_cnt", 64'(dut.cnt_q), 64'd0);
      chk("mid_rst_rr", 64'(dut.rr_q), 64'd0);
      chk("mid_rst_err", 64'(err_o), 64'd0);
      chk("mid_rst_req_o", 64'(req_o), 64'd0);
      nxt();
      rst_ni = 1'b1;
      req_i  = 8'h48;
      gnt_i  = 1'b1;
      exp_gnt(3);
      nxt();
      req_i = '0;
      gnt_i = 1'b0;
      resp(3);
      nxt();
      idle_resp();
      chk("post_rst_cnt", 64'(dut.cnt_q), 64'd0);

      // protocol errors: stale response, then non-one-hot id
      r_valid_i = 1'b1;
      r_id_i    = 8'h10;
      @(negedge clk_i);
      chk("err0_rvalid", 64'(r_valid_o), 64'd0);
      nxt();
      chk("err0_flag", 64'(err_o), 64'd1);
      chk("err0_cnt", 64'(dut.cnt_q), 64'd0);
      r_id_i = 8'h06;
      @(negedge clk_i);
      chk("err1_rvalid", 64'(r_valid_o), 64'd0);
      nxt();
      idle_resp();
      repeat (3) nxt();
      chk("err_sticky", 64'(err_o), 64'd1);
      rst_ni = 1'b0;
      #1;
      chk("err_rst", 64'(err_o), 64'd0);
      nxt();
      rst_ni = 1'b1;
      nxt();

      chk("gq_empty", 64'(gq.size()), 64'd0);
      chk("rq_empty", 64'(rq.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
